// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: character-cell text buffer with a cursor,
// a clear/scroll sequencer and a registered display read port.
module text_buffer_ctrl #(
   parameter int         ASCII_WIDTH = 7,
   parameter int         GRID_COL    = 10,
   parameter int         GRID_ROW    = 5,
   parameter int         SCROLL_EN   = 1,
   parameter logic [3:0] DEF_FG      = 4'h1,
   parameter logic [3:0] DEF_BG      = 4'h5,
   parameter int         CURSOR_CODE = 127,
   localparam int        W  = 9 + ASCII_WIDTH,
   localparam int        XW = $clog2(GRID_COL),
   localparam int        YW = $clog2(GRID_ROW)
) (
   input  logic                   clk_pix,
   input  logic                   rst,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [2:0]             wr_cmd,
   input  logic [ASCII_WIDTH-1:0] wr_ascii,
   input  logic [3:0]             wr_fg,
   input  logic [3:0]             wr_bg,
   input  logic [XW-1:0]          rd_x,
   input  logic [YW-1:0]          rd_y,
   output logic [W-1:0]           rd_data,
   output logic [XW-1:0]          cursor_x,
   output logic [YW-1:0]          cursor_y,
   output logic                   busy
);

   localparam int N  = GRID_COL * GRID_ROW;
   localparam int CW = $clog2(N);

   localparam logic [CW-1:0] LAST  = CW'(N - 1);
   localparam logic [CW-1:0] KEEP  = CW'(N - GRID_COL);
   localparam logic [CW-1:0] ROWW  = CW'(GRID_COL);
   localparam logic [XW-1:0] XLAST = XW'(GRID_COL - 1);
   localparam logic [YW-1:0] YLAST = YW'(GRID_ROW - 1);
   localparam logic [W-1:0]  BLANK =
      {DEF_FG, DEF_BG, 1'b1, {ASCII_WIDTH{1'b0}}};

   localparam logic [2:0] C_PUTCH = 3'd0;
   localparam logic [2:0] C_NL    = 3'd1;
   localparam logic [2:0] C_CLEAR = 3'd2;
   localparam logic [2:0] C_BKSP  = 3'd3;
   localparam logic [2:0] C_LEFT  = 3'd4;
   localparam logic [2:0] C_RIGHT = 3'd5;

   typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [XW-1:0] cx_q;
   logic [YW-1:0] cy_q;
   logic [W-1:0]  mem_q [N];
   logic [W-1:0]  rd_q;

   logic [CW-1:0] cur_lin;
   logic [CW-1:0] rd_lin;
   logic          accept;
   logic          at_first;
   logic          at_last;
   logic          eos;
   logic          rd_ok;
   logic [XW-1:0] fwd_x;
   logic [XW-1:0] bwd_x;
   logic [YW-1:0] fwd_y;
   logic [YW-1:0] bwd_y;
   logic          we_d;
   logic [CW-1:0] waddr_d;
   logic [W-1:0]  wdata_d;
   logic [W-1:0]  rd_d;

   assign wr_ready = (state_q == IDLE) && !rst;
   assign busy     = (state_q != IDLE);
   assign accept   = wr_valid && wr_ready;
   assign cur_lin  = CW'(cy_q) * ROWW + CW'(cx_q);
   assign at_first = (cur_lin == '0);
   assign at_last  = (cur_lin == LAST);
   assign eos      = (wr_cmd == C_PUTCH && at_last) ||
                     (wr_cmd == C_NL && cy_q == YLAST);

   always_comb begin
      fwd_x = cx_q + XW'(1);
      fwd_y = cy_q;
      if (cx_q == XLAST) begin
         fwd_x = '0;
         fwd_y = cy_q + YW'(1);
      end
      bwd_x = cx_q - XW'(1);
      bwd_y = cy_q;
      if (cx_q == '0) begin
         bwd_x = XLAST;
         bwd_y = cy_q - YW'(1);
      end
   end

   always_ff @(posedge clk_pix) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
      end else begin
         case (state_q)
            CLEAR, SCROLL: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  if (state_q == CLEAR) begin
                     cx_q <= '0;
                     cy_q <= '0;
                  end
               end
            end
            default: begin
               if (accept && eos) begin
                  cx_q <= '0;
                  if (SCROLL_EN != 0) begin
                     state_q <= SCROLL;
                     cnt_q   <= '0;
                     cy_q    <= YLAST;
                  end else begin
                     cy_q <= '0;
                  end
               end else if (accept) begin
                  case (wr_cmd)
                     C_PUTCH: begin
                        cx_q <= fwd_x;
                        cy_q <= fwd_y;
                     end
                     C_RIGHT: if (!at_last) begin
                        cx_q <= fwd_x;
                        cy_q <= fwd_y;
                     end
                     C_NL: begin
                        cx_q <= '0;
                        cy_q <= cy_q + YW'(1);
                     end
                     C_CLEAR: begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                     end
                     C_BKSP, C_LEFT: if (!at_first) begin
                        cx_q <= bwd_x;
                        cy_q <= bwd_y;
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   // One write port shared by the sequencer and the command path.
   always_comb begin
      we_d    = 1'b0;
      waddr_d = cnt_q;
      wdata_d = BLANK;
      if (!rst) begin
         case (state_q)
            CLEAR: we_d = 1'b1;
            SCROLL: begin
               we_d = 1'b1;
               if (cnt_q < KEEP) wdata_d = mem_q[cnt_q + ROWW];
            end
            default: begin
               if (accept && wr_cmd == C_PUTCH) begin
                  we_d    = 1'b1;
                  waddr_d = cur_lin;
                  wdata_d = {wr_fg, wr_bg, 1'b1, wr_ascii};
               end else if (accept && wr_cmd == C_BKSP && !at_first) begin
                  we_d    = 1'b1;
                  waddr_d = cur_lin - CW'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_pix) begin
      if (we_d) mem_q[waddr_d] <= wdata_d;
   end

   always_comb begin
      rd_ok  = (int'(rd_x) < GRID_COL) && (int'(rd_y) < GRID_ROW);
      rd_lin = CW'(rd_y) * ROWW + CW'(rd_x);
      rd_d   = BLANK;
      if (rd_ok) begin
         rd_d = mem_q[rd_lin];
         if (state_q == IDLE && rd_x == cx_q && rd_y == cy_q)
            rd_d[ASCII_WIDTH-1:0] = ASCII_WIDTH'(CURSOR_CODE);
      end
   end

   always_ff @(posedge clk_pix) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_d;
   end

   assign rd_data  = rd_q;
   assign cursor_x = cx_q;
   assign cursor_y = cy_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Bench for text_buffer_ctrl: constant vector table, directed
// corner sequences and a random run against a cell-array model.
module tb_text_buffer_ctrl;

   localparam int COL = 10;
   localparam int ROW = 5;
   localparam int N   = COL * ROW;
   localparam logic [15:0] BLANK = 16'h1580;

   logic        clk_pix = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [2:0]  wr_cmd = 3'd6;
   logic [6:0]  wr_ascii = '0;
   logic [3:0]  wr_fg = '0;
   logic [3:0]  wr_bg = '0;
   logic [3:0]  rd_x = '0;
   logic [2:0]  rd_y = '0;
   logic [15:0] rd_data;
   logic [3:0]  cursor_x;
   logic [2:0]  cursor_y;
   logic        busy;

   always #5 clk_pix = ~clk_pix;

   text_buffer_ctrl dut (
      .clk_pix (clk_pix),
      .rst     (rst),
      .wr_valid(wr_valid),
      .wr_ready(wr_ready),
      .wr_cmd  (wr_cmd),
      .wr_ascii(wr_ascii),
      .wr_fg   (wr_fg),
      .wr_bg   (wr_bg),
      .rd_x    (rd_x),
      .rd_y    (rd_y),
      .rd_data (rd_data),
      .cursor_x(cursor_x),
      .cursor_y(cursor_y),
      .busy    (busy)
   );

   int errors = 0;
   int checks = 0;

   logic [15:0] mm [N];
   int mcur;

   typedef struct {
      logic [2:0]  cmd;
      logic [6:0]  asc;
      logic [3:0]  fg;
      logic [3:0]  bg;
      int          ex;
      int          ey;
      int          rx;
      int          ry;
      logic [15:0] erd;
   } vec_t;

   vec_t tbl [10];

   task automatic tick();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) mm[i] = BLANK;
      mcur = 0;
   endfunction

   function automatic int model_eos();
      for (int i = 0; i < N; i++) begin
         if (i < N - COL) mm[i] = mm[i + COL];
         else             mm[i] = BLANK;
      end
      mcur = (ROW - 1) * COL;
      return N;
   endfunction

   function automatic int model_apply(input logic [2:0] c,
                                      input logic [6:0] a,
                                      input logic [3:0] f,
                                      input logic [3:0] b);
      int row;
      row = mcur / COL;
      case (c)
         3'd0: begin
            mm[mcur] = {f, b, 1'b1, a};
            if (mcur == N - 1) return model_eos();
            mcur++;
         end
         3'd1: begin
            if (row == ROW - 1) return model_eos();
            mcur = (row + 1) * COL;
         end
         3'd2: begin
            model_reset();
            return N;
         end
         3'd3: if (mcur > 0) begin
            mcur--;
            mm[mcur] = BLANK;
         end
         3'd4: if (mcur > 0) mcur--;
         3'd5: if (mcur < N - 1) mcur++;
         default: ;
      endcase
      return 0;
   endfunction

   function automatic logic [15:0] exp_rd(input int x, input int y);
      logic [15:0] v;
      if (x >= COL || y >= ROW) return BLANK;
      v = mm[y * COL + x];
      if (y * COL + x == mcur) v[6:0] = 7'h7F;
      return v;
   endfunction

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!wr_ready && n < 300) begin
         tick();
         n++;
      end
      if (!wr_ready) begin
         checks++;
         errors++;
         $display("FAIL %s: wr_ready still %0b after %0d cycles",
                  name, wr_ready, n);
      end
   endtask

   task automatic send(input logic [2:0] c, input logic [6:0] a,
                       input logic [3:0] f, input logic [3:0] b);
      int n;
      int bz;
      wait_ready("send_ready");
      wr_valid = 1'b1;
      wr_cmd   = c;
      wr_ascii = a;
      wr_fg    = f;
      wr_bg    = b;
      tick();
      wr_valid = 1'b0;
      wr_cmd   = 3'd6;
      bz = model_apply(c, a, f, b);
      if (bz > 0) begin
         chk("busy_start", busy, 1);
         n = 0;
         while (busy && n < 300) begin
            tick();
            n++;
         end
         chk("busy_len", n, bz);
      end
   endtask

   task automatic check_cursor(input string name);
      chk({name, "_x"}, cursor_x, mcur % COL);
      chk({name, "_y"}, cursor_y, mcur / COL);
   endtask

   task automatic check_read(input int x, input int y, input string name);
      rd_x = 4'(x);
      rd_y = 3'(y);
      tick();
      chk($sformatf("%s(%0d,%0d)", name, x, y), rd_data, exp_rd(x, y));
   endtask

   task automatic check_all(input string name);
      for (int y = 0; y < ROW; y++)
         for (int x = 0; x < COL; x++)
            check_read(x, y, name);
   endtask

   task automatic reset_and_check(input string name);
      int n;
      n = 0;
      while (!wr_ready && n < 300) begin
         tick();
         n++;
      end
      chk({name, "_clear_len"}, n, N);
      model_reset();
      check_cursor({name, "_cursor"});
      check_all({name, "_blank"});
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{3'd0, 7'h41, 4'h2, 4'h0, 1, 0, 0, 0, 16'h20C1};
      tbl[1] = '{3'd0, 7'h42, 4'h3, 4'h1, 2, 0, 1, 0, 16'h31C2};
      tbl[2] = '{3'd4, 7'h00, 4'h0, 4'h0, 1, 0, 1, 0, 16'h31FF};
      tbl[3] = '{3'd5, 7'h00, 4'h0, 4'h0, 2, 0, 2, 0, 16'h15FF};
      tbl[4] = '{3'd3, 7'h00, 4'h0, 4'h0, 1, 0, 1, 0, 16'h15FF};
      tbl[5] = '{3'd1, 7'h00, 4'h0, 4'h0, 0, 1, 0, 0, 16'h20C1};
      tbl[6] = '{3'd6, 7'h00, 4'h0, 4'h0, 0, 1, 15, 0, 16'h1580};
      tbl[7] = '{3'd7, 7'h00, 4'h0, 4'h0, 0, 1, 0, 7, 16'h1580};
      tbl[8] = '{3'd4, 7'h00, 4'h0, 4'h0, 9, 0, 9, 0, 16'h15FF};
      tbl[9] = '{3'd4, 7'h00, 4'h0, 4'h0, 8, 0, 1, 0, 16'h1580};

      // Power-up reset held for one edge.
      rst = 1'b1;
      tick();
      chk("rst_rd_data", rd_data, 16'h0);
      chk("rst_ready", wr_ready, 0);
      chk("rst_busy", busy, 1);
      chk("rst_cur_x", cursor_x, 0);
      rst = 1'b0;
      reset_and_check("por");
      check_read(0, 0, "cursor_cell");

      for (int i = 0; i < 10; i++) begin
         send(tbl[i].cmd, tbl[i].asc, tbl[i].fg, tbl[i].bg);
         chk($sformatf("tbl%0d_cx", i), cursor_x, tbl[i].ex);
         chk($sformatf("tbl%0d_cy", i), cursor_y, tbl[i].ey);
         rd_x = 4'(tbl[i].rx);
         rd_y = 3'(tbl[i].ry);
         tick();
         chk($sformatf("tbl%0d_rd", i), rd_data, tbl[i].erd);
      end

      // Ten characters fill row 0, then a newline.
      send(3'd2, 7'h0, 4'h0, 4'h0);
      for (int i = 0; i < COL; i++)
         send(3'd0, 7'(8'h61 + i), 4'($urandom), 4'($urandom));
      check_cursor("row_wrap");
      send(3'd1, 7'h0, 4'h0, 4'h0);
      chk("nl_cx", cursor_x, 0);
      chk("nl_cy", cursor_y, 2);
      check_all("row0_kept");

      // Backspace / left / right boundaries.
      send(3'd2, 7'h0, 4'h0, 4'h0);
      for (int i = 0; i < 12; i++) send(3'd5, 7'h0, 4'h0, 4'h0);
      send(3'd0, 7'h78, 4'h6, 4'h7);
      check_cursor("at_3_1");
      send(3'd3, 7'h0, 4'h0, 4'h0);
      chk("bs_cx", cursor_x, 2);
      chk("bs_cy", cursor_y, 1);
      send(3'd5, 7'h0, 4'h0, 4'h0);
      check_read(2, 1, "bs_blank");
      for (int i = 0; i < 13; i++) send(3'd4, 7'h0, 4'h0, 4'h0);
      check_cursor("home");
      send(3'd3, 7'h0, 4'h0, 4'h0);
      chk("bs0_cx", cursor_x, 0);
      chk("bs0_cy", cursor_y, 0);
      check_read(1, 0, "bs0_cell");
      send(3'd4, 7'h0, 4'h0, 4'h0);
      chk("left0_cx", cursor_x, 0);
      chk("left0_cy", cursor_y, 0);
      for (int i = 0; i < N - 1; i++) send(3'd5, 7'h0, 4'h0, 4'h0);
      send(3'd5, 7'h0, 4'h0, 4'h0);
      chk("rightN_cx", cursor_x, 9);
      chk("rightN_cy", cursor_y, 4);

      // Fill the whole screen: the last PUTCH scrolls.
      send(3'd2, 7'h0, 4'h0, 4'h0);
      for (int i = 0; i < N; i++)
         send(3'd0, 7'($urandom), 4'($urandom), 4'($urandom));
      chk("scroll_cx", cursor_x, 0);
      chk("scroll_cy", cursor_y, 4);
      check_all("scrolled");

      // Random commands against the model.
      for (int it = 0; it < 400; it++) begin
         int r;
         logic [2:0] c;
         r = $urandom_range(0, 19);
         if (r < 10)       c = 3'd0;
         else if (r == 10) c = 3'd1;
         else if (r == 11) c = ($urandom_range(0, 3) == 0) ? 3'd2 : 3'd6;
         else if (r < 14)  c = 3'd3;
         else if (r < 16)  c = 3'd4;
         else if (r < 18)  c = 3'd5;
         else              c = 3'(6 + (r & 1));
         send(c, 7'($urandom), 4'($urandom), 4'($urandom));
         check_cursor("rnd_cursor");
         check_read($urandom_range(0, 15), $urandom_range(0, 7), "rnd_rd");
         if (it % 100 == 99) check_all("rnd_all");
      end

      // Reset in the middle of a scroll with a request pending.
      send(3'd2, 7'h0, 4'h0, 4'h0);
      for (int i = 0; i < N - 1; i++) send(3'd5, 7'h0, 4'h0, 4'h0);
      wait_ready("mid_ready");
      wr_valid = 1'b1;
      wr_cmd   = 3'd0;
      wr_ascii = 7'h55;
      tick();
      chk("mid_scroll_busy", busy, 1);
      wr_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      wr_valid = 1'b1;
      wr_cmd   = 3'd0;
      rst      = 1'b1;
      chk("mid_rst_ready", wr_ready, 0);
      tick();
      chk("mid_rst_rd", rd_data, 16'h0);
      chk("mid_rst_cx", cursor_x, 0);
      chk("mid_rst_cy", cursor_y, 0);
      rst      = 1'b0;
      wr_valid = 1'b0;
      wr_cmd   = 3'd6;
      reset_and_check("mid");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/text_buffer_ctrl.md
TEXT_BUFFER_CTRL -- requirements
Module: text_buffer_ctrl

Interface
REQ-001 Parameter ASCII_WIDTH, default 7, sets the character code width; entry width W = 9+ASCII_WIDTH.
REQ-002 Parameter GRID_COL, default 10, sets the number of character columns.
REQ-003 Parameter GRID_ROW, default 5, sets the number of character rows; N = GRID_COL*GRID_ROW cells.
REQ-004 Parameter SCROLL_EN, default 1: 1 = scroll up at end of screen, 0 = wrap cursor to cell 0.
REQ-005 Parameter DEF_FG, default 4'h1, and DEF_BG, default 4'h5, set the blank-cell colours.
REQ-006 Parameter CURSOR_CODE, default 127, sets the glyph code shown at the cursor cell.
REQ-007 Port clk_pix, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 Port rst, input, 1 bit: synchronous reset, active-high.
REQ-009 Port wr_valid, input, 1 bit: command request.
REQ-010 Port wr_ready, output, 1 bit: command accepted when wr_valid && wr_ready on a rising edge.
REQ-011 Port wr_cmd, input, 3 bits: 0 PUTCH, 1 NEWLINE, 2 CLEAR, 3 BACKSPACE, 4 LEFT, 5 RIGHT, 6-7 NOP.
REQ-012 Port wr_ascii, input, ASCII_WIDTH bits: character code for PUTCH.
REQ-013 Ports wr_fg and wr_bg, input, 4 bits each: foreground and background colour for PUTCH.
REQ-014 Ports rd_x, input, $clog2(GRID_COL) bits, and rd_y, input, $clog2(GRID_ROW) bits: display read address.
REQ-015 Port rd_data, output, W bits: registered cell {fg,bg,valid,ascii}.
REQ-016 Ports cursor_x and cursor_y, output, same widths as rd_x and rd_y: current cursor cell.
REQ-017 Port busy, output, 1 bit: high while in CLEAR or SCROLL.

Function
REQ-018 The blank entry SHALL be {DEF_FG, DEF_BG, 1'b1, 0}.
REQ-019 The FSM SHALL have states IDLE, CLEAR and SCROLL; wr_ready = (state==IDLE) && !rst; busy = (state!=IDLE).
REQ-020 CLEAR SHALL write blank to one cell per cycle at index 0..N-1, then go to IDLE and set the cursor to (0,0); it lasts exactly N cycles.
REQ-021 SCROLL SHALL copy cell i+GRID_COL to cell i for i = 0..N-GRID_COL-1, one per cycle, then blank the last row, one cell per cycle, then go to IDLE; it lasts exactly N cycles.
REQ-022 PUTCH SHALL write {wr_fg,wr_bg,1,wr_ascii} at the cursor cell on the accept edge and advance the cursor one cell; the end of a column advances to column 0 of the next row.
REQ-023 PUTCH at the last cell: if SCROLL_EN=1, enter SCROLL with the cursor at (0,GRID_ROW-1); otherwise the cursor goes to (0,0) with no scroll.
REQ-024 NEWLINE SHALL move the cursor to (0,y+1); on the last row it follows the REQ-023 end-of-screen rule; no cell is written.
REQ-025 BACKSPACE SHALL move the cursor back one linear cell and write blank there; at (0,0) it SHALL have no effect.
REQ-026 LEFT SHALL move the cursor back one linear cell and RIGHT forward one; LEFT at cell 0 and RIGHT at cell N-1 SHALL hold the cursor; neither writes.
REQ-027 CLEAR command SHALL enter the CLEAR state; NOP SHALL be accepted with no effect.
REQ-028 rd_data SHALL have 1-cycle latency from rd_x/rd_y; when (rd_x,rd_y)==cursor and state==IDLE, its ascii field SHALL be CURSOR_CODE with the colour fields of the stored cell.
REQ-029 rd_x>=GRID_COL or rd_y>=GRID_ROW SHALL return the blank entry.
REQ-030 Reads during CLEAR/SCROLL SHALL return current memory contents with no cursor overlay.
REQ-031 Cursor arithmetic SHALL use linear index y*GRID_COL+x, width $clog2(N), with explicit wrap and no reliance on power-of-two overflow.

Reset
REQ-032 rst SHALL force state CLEAR, the clear counter to 0, the cursor to (0,0), rd_data to 0 and wr_ready to 0; it overrides any in-progress CLEAR/SCROLL or a simultaneous accept.
REQ-033 After rst deasserts, wr_ready SHALL rise exactly N cycles later with all cells blank.

Verification
REQ-034 Reset 1 cycle, defaults -> wr_ready low for 50 cycles, then high; every rd_data = 16'h1580, except the cursor cell (0,0) = 16'h15FF.
REQ-035 PUTCH 'A' (7'h41), fg=2, bg=0 -> the next read of (0,0) = 16'h20C1 and the cursor is (1,0).
REQ-036 Ten PUTCHs on row 0, then NEWLINE -> the cursor moves (0,1) then (0,2); row 0 is unchanged.
REQ-037 Fill all 50 cells with SCROLL_EN=1 -> busy for 50 cycles; row 0 holds the former row 1, row 4 is blank, and the cursor is (0,4).
REQ-038 BACKSPACE at (3,1) -> cursor (2,1) and cell (2,1) blank; BACKSPACE at (0,0) -> no change; LEFT at (0,0) and RIGHT at (9,4) -> the cursor holds.
REQ-039 rst asserted mid-SCROLL with wr_valid high -> no accept occurs; a full CLEAR runs and the cursor is (0,0).
